pipe_controller: RTL

//  Pipelined control unit for the 5-stage RV32I core. Decodes opcode/funct3/funct7
//  of the instruction in Decode and drives the datapath control inputs.

---
 rtl/pipe_controller.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_controller.sv
// pipe_controller: RV32I control decode for the instruction in Decode, plus the
// D->E->M->W control pipeline and the redirect squash window that kills the
// younger instructions behind a taken branch/jump resolving in Execute.
module pipe_controller #(
  parameter int SQUASH_SLOTS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_taken_E,
  output logic [2:0] ImmSrc,
  output logic       sel_A_E,
  output logic       sel_B_E,
  output logic [3:0] alu_op_E,
  output logic [2:0] br_type_E,
  output logic [2:0] wr_en_M,
  output logic [2:0] rd_en_M,
  output logic       reg_wr_W,
  output logic [1:0] wb_sel_W,
  output logic       illegal_seen
);

  localparam int CW = (SQUASH_SLOTS > 1) ? $clog2(SQUASH_SLOTS) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] BR_ALWAYS = 3'd7;

  localparam logic [1:0] WB_PC4 = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  // One control word as it travels into Execute; all-zero is a bubble.
  typedef struct packed {
    logic       sel_a;
    logic       sel_b;
    logic [3:0] alu_op;
    logic [2:0] br_type;
    logic [2:0] wr_en;
    logic [2:0] rd_en;
    logic       reg_wr;
    logic [1:0] wb_sel;
  } ctl_t;

  ctl_t          dec;
  ctl_t          e_next;
  ctl_t          ctl_e;
  logic          dec_illegal;
  logic          kill;
  logic [CW-1:0] squash_cnt;
  logic          reg_wr_m;
  logic [1:0]    wb_sel_m;

  // Only funct7[5] matters for RV32I base decode; the other bits are ignored.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // funct3 picks the ALU op; alt (funct7[5]) turns ADD into SUB (R-type only)
  // and SRL into SRA (both R-type and immediate shifts).
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       alt,
                                            input logic       is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Decode the instruction sitting in D into a control word and immediate type.
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    ImmSrc      = IMM_I;
    case (opcode)
      OP_R: begin
        dec.sel_a  = 1'b1;
        dec.alu_op = alu_decode(funct3, funct7[5], 1'b1);
        dec.reg_wr = 1'b1;
        dec.wb_sel = WB_ALU;
      end
      OP_IMM: begin
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.alu_op = alu_decode(funct3, funct7[5], 1'b0);
        dec.reg_wr = 1'b1;
        dec.wb_sel = WB_ALU;
      end
      OP_LOAD: begin
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = WB_MEM;
        case (funct3)
          3'b000:  dec.rd_en = 3'd1;
          3'b001:  dec.rd_en = 3'd2;
          3'b010:  dec.rd_en = 3'd3;
          3'b100:  dec.rd_en = 3'd4;
          3'b101:  dec.rd_en = 3'd5;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        ImmSrc    = IMM_S;
        dec.sel_a = 1'b1;
        dec.sel_b = 1'b1;
        case (funct3)
          3'b000:  dec.wr_en = 3'd1;
          3'b001:  dec.wr_en = 3'd2;
          3'b010:  dec.wr_en = 3'd3;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        ImmSrc    = IMM_B;
        dec.sel_b = 1'b1;
        case (funct3)
          3'b000:  dec.br_type = 3'd1;
          3'b001:  dec.br_type = 3'd2;
          3'b100:  dec.br_type = 3'd3;
          3'b101:  dec.br_type = 3'd4;
          3'b110:  dec.br_type = 3'd5;
          3'b111:  dec.br_type = 3'd6;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        ImmSrc     = IMM_U;
        dec.sel_b  = 1'b1;
        dec.alu_op = ALU_PASSB;
        dec.reg_wr = 1'b1;
        dec.wb_sel = WB_ALU;
      end
      OP_AUIPC: begin
        ImmSrc     = IMM_U;
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = WB_ALU;
      end
      OP_JAL: begin
        ImmSrc      = IMM_J;
        dec.sel_b   = 1'b1;
        dec.br_type = BR_ALWAYS;
        dec.reg_wr  = 1'b1;
        dec.wb_sel  = WB_PC4;
      end
      OP_JALR: begin
        dec.sel_a   = 1'b1;
        dec.sel_b   = 1'b1;
        dec.br_type = BR_ALWAYS;
        dec.reg_wr  = 1'b1;
        dec.wb_sel  = WB_PC4;
        if (funct3 != 3'b000) dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A redirect this edge, or an open squash window, turns the D slot into a bubble.
  assign kill   = br_taken_E || (squash_cnt != '0);
  assign e_next = (dec_illegal || kill) ? '0 : dec;

  // Squash window counter: reloads on every redirect, then counts down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      squash_cnt <= '0;
    end else if (br_taken_E) begin
      squash_cnt <= CW'(SQUASH_SLOTS - 1);
    end else if (squash_cnt != '0) begin
      squash_cnt <= squash_cnt - CW'(1);
    end
  end

  // D->E control register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_e <= '0;
    end else begin
      ctl_e <= e_next;
    end
  end

  // E->M and M->W registers always advance; redirects never touch older work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_M  <= '0;
      rd_en_M  <= '0;
      reg_wr_m <= 1'b0;
      wb_sel_m <= '0;
      reg_wr_W <= 1'b0;
      wb_sel_W <= '0;
    end else begin
      wr_en_M  <= ctl_e.wr_en;
      rd_en_M  <= ctl_e.rd_en;
      reg_wr_m <= ctl_e.reg_wr;
      wb_sel_m <= ctl_e.wb_sel;
      reg_wr_W <= reg_wr_m;
      wb_sel_W <= wb_sel_m;
    end
  end

  // Sticky flag: an undecodable, non-squashed instruction entered Execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_seen <= 1'b0;
    end else if (dec_illegal && !kill) begin
      illegal_seen <= 1'b1;
    end
  end

  assign sel_A_E   = ctl_e.sel_a;
  assign sel_B_E   = ctl_e.sel_b;
  assign alu_op_E  = ctl_e.alu_op;
  assign br_type_E = ctl_e.br_type;

endmodule
